// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries the EX result to MEM and parks the MADD/MSUB
// accumulator temporaries while EX is stalled.
module ex_mem #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ALUOP_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic                  mem_valid,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic kill;
    logic bubble;
    logic advance;
    logic unused_stall;

    assign kill         = !rst || flush;
    // EX held while MEM moves on: a bubble enters MEM. stall[3]=0,stall[4]=1 falls into advance.
    assign bubble       = stall[3] && !stall[4];
    assign advance      = !stall[3];
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk) begin
        if (kill || bubble) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_valid    <= 1'b0;
        end else if (advance) begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            mem_valid    <= 1'b1;
        end

        // Temporaries live only across the stalled MADD/MSUB cycle.
        if (kill || advance) begin
            hilo_o <= '0;
            cnt_o  <= 2'd0;
        end else if (bubble) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for the EX/MEM pipeline register.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    ex_mem dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_whilo     (ex_whilo),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .hilo_i       (hilo_i),
        .cnt_i        (cnt_i),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .mem_valid    (mem_valid),
        .hilo_o       (hilo_o),
        .cnt_o        (cnt_o)
    );

    always #5 clk = ~clk;

    // The stall vector is monotonic: MEM never held while EX moves.
    always @(posedge clk) begin
        assert (!(stall[4] && !stall[3]))
        else $error("illegal stall vector %b", stall);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wd"},    64'(mem_wd), 64'd0);
        check({tag, ".wreg"},  64'(mem_wreg), 64'd0);
        check({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, ".whilo"}, 64'(mem_whilo), 64'd0);
        check({tag, ".hi"},    64'(mem_hi), 64'd0);
        check({tag, ".lo"},    64'(mem_lo), 64'd0);
        check({tag, ".aluop"}, 64'(mem_aluop), 64'd0);
        check({tag, ".addr"},  64'(mem_mem_addr), 64'd0);
        check({tag, ".reg2"},  64'(mem_reg2), 64'd0);
        check({tag, ".valid"}, 64'(mem_valid), 64'd0);
        check({tag, ".hilo"},  hilo_o, 64'd0);
        check({tag, ".cnt"},   64'(cnt_o), 64'd0);
    endtask

    task automatic drive_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        ex_wd       = wd;
        ex_wreg     = wreg;
        ex_wdata    = wdata;
        ex_whilo    = whilo;
        ex_hi       = hi;
        ex_lo       = lo;
        ex_aluop    = 8'h23;
        ex_mem_addr = 32'h1000_0040;
        ex_reg2     = 32'hA5A5_0F0F;
    endtask

    logic [31:0] v_wdata [3];
    logic        v_whilo [3];
    logic [31:0] v_hi    [3];
    logic [31:0] v_lo    [3];

    initial begin
        rst    = 1'b0;
        stall  = 6'b0;
        flush  = 1'b0;
        hilo_i = 64'hFFFF_0000_FFFF_0000;
        cnt_i  = 2'd2;
        drive_ex(5'($urandom), 1'b1, $urandom, 1'b1, $urandom, $urandom);

        // 1: reset for two edges, then release
        tick();
        check_all_zero("rst1");
        tick();
        check_all_zero("rst2");
        rst      = 1'b1;
        ex_wdata = 32'hCAFE_0001;
        tick();
        check("rel.wdata", 64'(mem_wdata), 64'hCAFE_0001);
        check("rel.valid", 64'(mem_valid), 64'd1);

        // 2: plain advance; stall bits outside [4:3] must not matter
        stall = 6'b100111;
        drive_ex(5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
        tick();
        check("adv.wd",    64'(mem_wd), 64'd5);
        check("adv.wreg",  64'(mem_wreg), 64'd1);
        check("adv.wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("adv.valid", 64'(mem_valid), 64'd1);
        check("adv.aluop", 64'(mem_aluop), 64'h23);
        check("adv.addr",  64'(mem_mem_addr), 64'h1000_0040);
        check("adv.reg2",  64'(mem_reg2), 64'hA5A5_0F0F);

        // 3: MADD/MSUB bubble captures temporaries, next advance clears them
        stall  = 6'b001000;
        hilo_i = 64'h1234_5678_9ABC_DEF0;
        cnt_i  = 2'd1;
        tick();
        check("bub.wreg",  64'(mem_wreg), 64'd0);
        check("bub.wdata", 64'(mem_wdata), 64'd0);
        check("bub.valid", 64'(mem_valid), 64'd0);
        check("bub.hilo",  hilo_o, 64'h1234_5678_9ABC_DEF0);
        check("bub.cnt",   64'(cnt_o), 64'd1);
        stall = 6'b000000;
        tick();
        check("bub2.hilo",  hilo_o, 64'd0);
        check("bub2.cnt",   64'(cnt_o), 64'd0);
        check("bub2.valid", 64'(mem_valid), 64'd1);

        // 4: hold after loading 0x55
        drive_ex(5'd9, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
        tick();
        stall    = 6'b011000;
        ex_wdata = 32'h7777_7777;
        hilo_i   = 64'hAAAA_BBBB_CCCC_DDDD;
        cnt_i    = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold.wdata", 64'(mem_wdata), 64'h55);
            check("hold.valid", 64'(mem_valid), 64'd1);
            check("hold.hilo",  hilo_o, 64'd0);
            check("hold.cnt",   64'(cnt_o), 64'd0);
        end
        // hold must also keep captured temporaries
        stall  = 6'b001000;
        hilo_i = 64'h0F0F_0F0F_1111_2222;
        cnt_i  = 2'd1;
        tick();
        stall  = 6'b011000;
        hilo_i = 64'h9999_9999_9999_9999;
        cnt_i  = 2'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold2.hilo",  hilo_o, 64'h0F0F_0F0F_1111_2222);
            check("hold2.cnt",   64'(cnt_o), 64'd1);
            check("hold2.valid", 64'(mem_valid), 64'd0);
        end

        // 5: flush beats advance, hold and coincides with reset
        stall = 6'b000000;
        drive_ex(5'd17, 1'b1, 32'h1357_9BDF, 1'b1, 32'h11, 32'h22);
        tick();
        flush = 1'b1;
        tick();
        check_all_zero("flush");
        flush = 1'b0;
        tick();
        check("preflush.valid", 64'(mem_valid), 64'd1);
        stall  = 6'b011000;
        flush  = 1'b1;
        tick();
        check_all_zero("flush_hold");
        stall = 6'b000000;
        rst   = 1'b0;
        tick();
        check_all_zero("flush_rst");
        flush = 1'b0;
        rst   = 1'b1;

        // 6: back-to-back advance, outputs lag inputs by one edge
        v_wdata = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0303};
        v_whilo = '{1'b1, 1'b0, 1'b1};
        v_hi    = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        v_lo    = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < 3; i++) begin
            drive_ex(5'(i + 1), 1'b1, v_wdata[i], v_whilo[i], v_hi[i], v_lo[i]);
            @(posedge clk);
            #1;
            check("b2b.wd",    64'(mem_wd), 64'(i + 1));
            check("b2b.wdata", 64'(mem_wdata), 64'(v_wdata[i]));
            check("b2b.whilo", 64'(mem_whilo), 64'(v_whilo[i]));
            check("b2b.hi",    64'(mem_hi), 64'(v_hi[i]));
            check("b2b.lo",    64'(mem_lo), 64'(v_lo[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
